// File: rtl/sdr_rd_capture.sv
`default_nettype none
// ============================================================================
// Module   : sdr_rd_capture
// Purpose  : Picks SDRAM read-burst words off DQ using CAS latency timing and
//            buffers them in a FWFT FIFO with READ-issue credit output.
// Revision : 1.0
// ============================================================================
module sdr_rd_capture #(
    parameter int DSIZE  = 32,
    parameter int FDEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [1:0]       cas_lat_i,
    input  logic [3:0]       burst_len_i,
    input  logic             rd_cmd_i,
    input  logic [DSIZE-1:0] dq_in_i,
    output logic             rd_allow_o,
    output logic [DSIZE-1:0] rd_data_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic             busy_o,
    output logic             err_o
);

    localparam int AW = $clog2(FDEPTH);
    localparam int CW = AW + 1;

    logic [DSIZE-1:0] mem_q [FDEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [CW-1:0]    occ_q,  occ_d;
    logic [CW-1:0]    pend_q, pend_d;
    logic [3:0]       cnt_q,  cnt_d;
    logic [3:0]       gap_q,  gap_d;
    logic [2:0]       sr_q,   sr_d;
    logic             err_q,  err_d;

    logic [CW:0]      w_used;
    logic [CW:0]      w_free;
    logic             w_credit_ok;
    logic             w_gap_ok;
    logic             w_accept;
    logic             w_tap;
    logic             w_push;
    logic             w_pop;

    // Credit counts words already stored plus words still owed by the SDRAM.
    assign w_used      = {1'b0, occ_q} + {1'b0, pend_q};
    assign w_free      = (CW+1)'(FDEPTH) - w_used;
    assign w_credit_ok = w_free >= (CW+1)'(burst_len_i);
    assign w_gap_ok    = gap_q >= burst_len_i;
    assign rd_allow_o  = w_credit_ok && w_gap_ok;
    assign w_accept    = rd_cmd_i && rd_allow_o;

    // Tap one stage early so word0 is pushed directly on the tap cycle.
    assign w_tap  = (cas_lat_i == 2'd3) ? sr_q[2] : sr_q[1];
    assign w_push = w_tap || (cnt_q != 4'd0);
    assign w_pop  = rd_valid_o && rd_ready_i;

    assign rd_data_o  = mem_q[rptr_q];
    assign rd_valid_o = (occ_q != '0);
    assign busy_o     = (pend_q != '0);
    assign err_o      = err_q;

    always_comb begin
        occ_d  = occ_q + CW'(w_push) - CW'(w_pop);
        pend_d = pend_q + (w_accept ? CW'(burst_len_i) : CW'(0)) - CW'(w_push);
        sr_d   = {sr_q[1:0], w_accept};
        err_d  = err_q | (rd_cmd_i & ~rd_allow_o);
        gap_d  = gap_q;
        if (w_accept) begin
            gap_d = 4'd1;
        end else if (gap_q < 4'd8) begin
            gap_d = gap_q + 4'd1;
        end
        cnt_d = cnt_q;
        if (w_tap) begin
            cnt_d = burst_len_i - 4'd1;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < FDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
            pend_q <= '0;
            cnt_q  <= 4'd0;
            gap_q  <= 4'd8;
            sr_q   <= 3'd0;
            err_q  <= 1'b0;
        end else begin
            if (w_push) begin
                mem_q[wptr_q] <= dq_in_i;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (w_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            occ_q  <= occ_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            gap_q  <= gap_d;
            sr_q   <= sr_d;
            err_q  <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdr_rd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdr_rd_capture
// Purpose  : Directed scoreboard bench for the SDR read-data capture stage.
// Revision : 1.0
// ============================================================================
module tb_sdr_rd_capture;

    typedef struct {
        int          start;
        int          bl;
        logic [31:0] base;
    } burst_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  cas = 2'd2;
    logic [3:0]  bl = 4'd4;
    logic        rd_cmd = 1'b0;
    logic        rd_ready = 1'b0;
    logic [31:0] dq = 32'd0;
    logic        rd_allow_o;
    logic [31:0] rd_data_o;
    logic        rd_valid_o;
    logic        busy_o;
    logic        err_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] base_next = 32'h1000;
    logic [31:0] exp_q[$];
    burst_t      sched_q[$];

    always #5 clk = ~clk;

    sdr_rd_capture #(.DSIZE(32), .FDEPTH(16)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .cas_lat_i  (cas),
        .burst_len_i(bl),
        .rd_cmd_i   (rd_cmd),
        .dq_in_i    (dq),
        .rd_allow_o (rd_allow_o),
        .rd_data_o  (rd_data_o),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: outputs sampled 1ns after the edge, then inputs driven.
    task automatic tick(input logic cmd, input logic rdy, input logic acc);
        int          idx;
        logic [31:0] w;
        burst_t      b;
        @(posedge clk);
        #1;
        cyc++;
        rd_cmd   = cmd;
        rd_ready = rdy;
        if (cmd) begin
            chk("rd_allow_at_cmd", rd_allow_o, acc);
            if (acc) begin
                b.start = cyc + int'(cas);
                b.bl    = int'(bl);
                b.base  = base_next;
                sched_q.push_back(b);
                base_next += 32'h10;
            end
        end
        if (sched_q.size() > 0 && cyc >= sched_q[0].start) begin
            idx = cyc - sched_q[0].start;
            w   = sched_q[0].base + 32'(idx);
            dq  = w;
            exp_q.push_back(w);
            if (idx == sched_q[0].bl - 1) void'(sched_q.pop_front());
        end else begin
            dq = $urandom;
        end
        if (rd_valid_o && rdy) begin
            chk("pop_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("rd_data", rd_data_o, exp_q.pop_front());
        end else if (rd_valid_o && exp_q.size() > 0) begin
            chk("rd_data_hold", rd_data_o, exp_q[0]);
        end
    endtask

    task automatic reset_checks();
        chk("rst_valid", rd_valid_o, 0);
        chk("rst_data",  rd_data_o,  0);
        chk("rst_busy",  busy_o,     0);
        chk("rst_err",   err_o,      0);
        chk("rst_allow", rd_allow_o, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        exp_q.delete();
        sched_q.delete();
        tick(0, 0, 0);
        reset_checks();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        tick(0, 0, 0);

        // Single burst, CAS 2, BL 4
        cas = 2'd2; bl = 4'd4; base_next = 32'hA0;
        tick(1, 1, 1);
        tick(0, 1, 0); chk("t1_busy_t1", busy_o, 1); chk("t1_valid_t1", rd_valid_o, 0);
        tick(0, 1, 0); chk("t1_valid_t2", rd_valid_o, 0);
        tick(0, 1, 0); chk("t1_valid_t3", rd_valid_o, 1);
        tick(0, 1, 0);
        tick(0, 1, 0); chk("t1_busy_t5", busy_o, 1);
        tick(0, 1, 0); chk("t1_busy_t6", busy_o, 0); chk("t1_valid_t6", rd_valid_o, 1);
        tick(0, 1, 0); chk("t1_valid_t7", rd_valid_o, 0);

        // Back-to-back BL 2 bursts, CAS 3
        cas = 2'd3; bl = 4'd2; base_next = 32'hB000;
        tick(1, 1, 1);
        tick(0, 1, 0);
        tick(1, 1, 1);
        tick(0, 1, 0);
        tick(1, 1, 1); chk("t2_valid_4", rd_valid_o, 1);
        for (int c = 5; c <= 10; c++) begin
            tick(0, 1, 0);
            chk("t2_stream_valid", rd_valid_o, 32'(c <= 9));
        end

        // Fill FIFO with two BL 8 bursts while host stalls
        do_reset();
        cas = 2'd2; bl = 4'd8; base_next = 32'hC000;
        tick(1, 0, 1);
        for (int i = 0; i < 7; i++) tick(0, 0, 0);
        tick(1, 0, 1);
        tick(0, 0, 0); chk("t3_allow_full", rd_allow_o, 0);
        for (int i = 0; i < 10; i++) tick(0, 0, 0);
        tick(1, 0, 0);
        tick(0, 0, 0); chk("t3_err", err_o, 1); chk("t3_busy", busy_o, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0);
            if (i == 7) chk("t3_allow_after7", rd_allow_o, 0);
        end
        tick(0, 0, 0); chk("t3_allow_after8", rd_allow_o, 1);
        for (int i = 0; i < 9; i++) tick(0, 1, 0);
        chk("t3_empty", rd_valid_o, 0);

        // Command inside the gap window is rejected
        do_reset();
        cas = 2'd2; bl = 4'd4; base_next = 32'hD000;
        tick(1, 1, 1);
        tick(0, 1, 0); chk("t4_allow_gap1", rd_allow_o, 0);
        tick(1, 1, 0);
        tick(0, 1, 0); chk("t4_err", err_o, 1);
        for (int i = 0; i < 10; i++) tick(0, 1, 0);
        chk("t4_err_sticky", err_o, 1);
        chk("t4_empty", rd_valid_o, 0);

        // Reset in the middle of a BL 8 burst
        do_reset();
        cas = 2'd2; bl = 4'd8; base_next = 32'hE000;
        tick(1, 0, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        tick(0, 0, 0); chk("t5_mid_valid", rd_valid_o, 1);
        reset_n = 1'b0;
        exp_q.delete();
        sched_q.delete();
        tick(0, 1, 0);
        reset_checks();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0);
            chk("t5_post_valid", rd_valid_o, 0);
        end
        chk("t5_post_busy", busy_o, 0);

        // BL 1 every cycle, pointers wrap several times
        cas = 2'd2; bl = 4'd1; base_next = 32'hF000;
        for (int i = 0; i < 40; i++) begin
            tick(1, 1, 1);
            if (i >= 3) chk("t6_stream_valid", rd_valid_o, 1);
        end
        for (int i = 0; i < 5; i++) tick(0, 1, 0);
        chk("t6_empty", rd_valid_o, 0);
        chk("t6_drained", 32'(exp_q.size()), 0);
        chk("t6_sched_done", 32'(sched_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdr_rd_capture.md
# sdr_rd_capture

Read-data capture stage placed directly downstream of the SDR data path's read output. It takes the raw SDRAM read bus, uses the controller's read-command strobe and the programmed CAS latency to pick out exactly the burst words, and buffers them in a small first-word-fall-through FIFO. The host drains the FIFO through a valid/ready handshake. A credit output tells the command sequencer when a new READ can be issued without overflowing the FIFO or overlapping a burst already in flight.

## Interface
Parameters:
- DSIZE, 32: data width; matches the controller data width.
- FDEPTH, 16: FIFO depth in words; power of two, at least 8.

Ports:
- CLK  in  1  system clock; single clock domain.
- RESET_N  in  1  reset; synchronous, active-low.
- CAS_LAT  in  2  CAS latency; legal values are 2 and 3. Changed only while BUSY is low.
- BURST_LEN  in  4  words per READ; legal values are 1, 2, 4, 8. Changed only while BUSY is low.
- RD_CMD  in  1  one-cycle pulse in the cycle the READ command is on the SDRAM bus.
- DQ_IN  in  DSIZE  read data from the data path; combinational from the pins.
- RD_ALLOW  out  1  a READ may be issued this cycle.
- RD_DATA  out  DSIZE  head-of-FIFO word.
- RD_VALID  out  1  RD_DATA is valid.
- RD_READY  in  1  host accepts RD_DATA.
- BUSY  out  1  a capture is pending or in progress.
- ERR  out  1  sticky flag; set when RD_CMD arrives while RD_ALLOW is low.

## Operation
- Command acceptance:
  - RD_CMD with RD_ALLOW high is accepted.
  - RD_CMD with RD_ALLOW low is ignored and sets ERR.
  - ERR is cleared only by reset.
- Capture timing: for a command accepted in cycle t, word k (k = 0..BURST_LEN-1) is sampled from DQ_IN at the clock edge ending cycle t+CAS_LAT+k and is pushed into the FIFO.
- Command tracking:
  - A shift register of depth 3 carries the accepted strobe and is tapped at CAS_LAT.
  - When the tapped strobe fires, it loads a burst counter with BURST_LEN.
  - While the burst counter is non-zero, each cycle pushes one word.
- Pending words (pend): words of accepted bursts not yet pushed.
  - pend increases by BURST_LEN on acceptance.
  - pend decreases by 1 on each push.
- Occupancy (occ): number of words stored in the FIFO.
- RD_ALLOW is combinational from registered state. It is high only when both conditions hold:
  - FDEPTH - occ - pend >= BURST_LEN.
  - The gap counter (cycles since the last acceptance, saturating at 8) is >= BURST_LEN.
- Consequences of the RD_ALLOW rules:
  - Back-to-back bursts are allowed at spacing of exactly BURST_LEN cycles.
  - Bursts never overlap.
  - The FIFO can never overflow.
- FIFO behaviour:
  - Pop occurs when RD_VALID and RD_READY are both high.
  - A push and a pop in the same cycle leave occ unchanged.
  - The read and write pointers are log2(FDEPTH) bits and wrap naturally.
- Flags:
  - RD_VALID = (occ != 0).
  - BUSY = (pend != 0).
- Reset mid-burst:
  - FIFO, pointers, pend, burst counter, shift register, gap counter and ERR all clear.
  - In-flight data is discarded; no partial word is pushed after reset is released.

## Timing
- Reset values:
  - RD_VALID = 0, RD_DATA = 0, BUSY = 0, ERR = 0.
  - RD_ALLOW = 1; after reset the gap counter starts saturated at 8.
- Latency from RD_CMD to word0 on RD_DATA/RD_VALID is CAS_LAT+1 cycles (word0 visible in cycle t+CAS_LAT+1) when the FIFO is empty.
- RD_DATA is registered FIFO storage. The head entry is stable while RD_VALID is high and RD_READY is low.
- Sustained throughput: one word per cycle in and out.
- RD_ALLOW falls in the cycle after an acceptance when the credit or gap condition no longer holds.

## Test plan
- CAS_LAT=2, BURST_LEN=4. RD_CMD at cycle 10, DQ_IN=0xA0..0xA3 in cycles 12..15, RD_READY=1 -> RD_VALID high in cycles 13..16 with RD_DATA 0xA0..0xA3 in order; BUSY high in cycles 11..15.
- CAS_LAT=3, BURST_LEN=2. RD_CMD at cycles 5, 7, 9 -> 6 words captured contiguously with no gaps or duplicates.
- BURST_LEN=8, FDEPTH=16, RD_READY=0. Two reads fill the FIFO -> RD_ALLOW=0 once 16 words are stored or pending; a third RD_CMD is ignored and ERR=1; after 8 pops RD_ALLOW returns to 1.
- BURST_LEN=4. RD_CMD at cycles 20 and 22 -> the second command is ignored (gap < 4), ERR sets, and only 4 words are captured.
- CAS_LAT=2, BURST_LEN=8. Assert RESET_N=0 for one cycle in the middle of the burst -> all outputs return to their reset values; the FIFO stays empty afterwards and the residual DQ_IN words are not captured.
- BURST_LEN=1 with RD_READY=1. Continuous RD_CMD every cycle -> occ stays at 1 (simultaneous push and pop) and pointers wrap past FDEPTH with data intact over 40 words.
